// File: rtl/parity_gen_pkg.sv
// Shared helpers for the parity generator: counter width derivation.
package parity_gen_pkg;

    // Bits needed to hold a population count of 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/parity_gen_if.sv
// Data/check/result bundle between a parity_gen instance and its user.
interface parity_gen_if
    import parity_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] a;
    logic             x;
    logic             in_valid;
    logic             chk_par;
    logic             out_valid;
    logic             x_q;
    logic [CNT_W-1:0] ones_q;
    logic             chk_err_q;

    modport master (
        output a, in_valid, chk_par,
        input  x, out_valid, x_q, ones_q, chk_err_q
    );

    modport slave (
        input  a, in_valid, chk_par,
        output x, out_valid, x_q, ones_q, chk_err_q
    );
endinterface

// File: rtl/parity_gen_popcount.sv
// Combinational ones-count and XOR reduction of a data word.
module parity_gen_popcount #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [CNT_W-1:0] ones,
    output logic             par
);
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CNT_W'(a[i]);
        end
        par = ^a;
    end
endmodule

// File: rtl/parity_gen.sv
// Even/odd parity generator and checker with a one-cycle registered, valid-qualified copy.
module parity_gen
    import parity_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ODD   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    parity_gen_if.slave   bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [CNT_W-1:0] ones;
    logic             par;
    logic             x;

    parity_gen_popcount #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_popcount (
        .a    (bus.a),
        .ones (ones),
        .par  (par)
    );

    assign x     = (ODD != 0) ? ~par : par;
    assign bus.x = x;

    // Result registers hold their last value while in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.x_q       <= 1'b0;
            bus.ones_q    <= '0;
            bus.chk_err_q <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.x_q       <= x;
                bus.ones_q    <= ones;
                bus.chk_err_q <= bus.chk_par ^ x;
            end
        end
    end
endmodule

// File: tb/tb_parity_gen.sv
// Directed bench for parity_gen: even and odd builds, registered path, hold and async reset.
module tb_parity_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    parity_gen_if #(.WIDTH(8)) bus_e ();
    parity_gen_if #(.WIDTH(8)) bus_o ();

    parity_gen #(.WIDTH(8), .ODD(0)) u_even (.clk(clk), .rst_n(rst_n), .bus(bus_e));
    parity_gen #(.WIDTH(8), .ODD(1)) u_odd  (.clk(clk), .rst_n(rst_n), .bus(bus_o));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_e(input logic v, input logic [7:0] d, input logic cp);
        bus_e.in_valid = v;
        bus_e.a        = d;
        bus_e.chk_par  = cp;
    endtask

    // Bit i is the even parity of i, for i = 0x00..0x14.
    logic [20:0] sweep_exp = 21'b0_1001_0110_1001_1001_0110;

    initial begin
        drive_e(1'b0, 8'h00, 1'b0);
        bus_o.in_valid = 1'b0;
        bus_o.a        = 8'h00;
        bus_o.chk_par  = 1'b0;

        #1;
        check("rst_out_valid", 32'(bus_e.out_valid), 32'd0);
        check("rst_x_q",       32'(bus_e.x_q),       32'd0);
        check("rst_ones_q",    32'(bus_e.ones_q),    32'd0);
        check("rst_chk_err_q", 32'(bus_e.chk_err_q), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i <= 20; i++) begin
            bus_e.a = 8'(i);
            #1;
            check($sformatf("sweep_x_%02h", i), 32'(bus_e.x), 32'(sweep_exp[i]));
        end

        // Registered path, all ones.
        @(negedge clk);
        drive_e(1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        check("ff_out_valid", 32'(bus_e.out_valid), 32'd1);
        check("ff_x_q",       32'(bus_e.x_q),       32'd0);
        check("ff_ones_q",    32'(bus_e.ones_q),    32'd8);
        check("ff_chk_err_q", 32'(bus_e.chk_err_q), 32'd0);

        // Error detect then clear.
        drive_e(1'b1, 8'h01, 1'b0);
        @(negedge clk);
        check("err1_chk_err_q", 32'(bus_e.chk_err_q), 32'd1);
        check("err1_x_q",       32'(bus_e.x_q),       32'd1);
        check("err1_ones_q",    32'(bus_e.ones_q),    32'd1);
        drive_e(1'b1, 8'h01, 1'b1);
        @(negedge clk);
        check("err0_chk_err_q", 32'(bus_e.chk_err_q), 32'd0);

        // Hold behaviour.
        drive_e(1'b1, 8'h07, 1'b1);
        @(negedge clk);
        check("hold_load_x_q",    32'(bus_e.x_q),    32'd1);
        check("hold_load_ones_q", 32'(bus_e.ones_q), 32'd3);
        drive_e(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check("hold_out_valid", 32'(bus_e.out_valid), 32'd0);
        check("hold_x_q",       32'(bus_e.x_q),       32'd1);
        check("hold_ones_q",    32'(bus_e.ones_q),    32'd3);
        check("hold_ones_lsb",  32'(bus_e.ones_q[0]), 32'(bus_e.x_q));
        @(negedge clk);
        check("hold2_ones_q",   32'(bus_e.ones_q),    32'd3);

        // Async reset between edges while out_valid is high.
        drive_e(1'b1, 8'h03, 1'b1);
        @(negedge clk);
        check("pre_rst_out_valid", 32'(bus_e.out_valid), 32'd1);
        check("pre_rst_chk_err_q", 32'(bus_e.chk_err_q), 32'd1);
        check("pre_rst_ones_q",    32'(bus_e.ones_q),    32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus_e.out_valid), 32'd0);
        check("arst_x_q",       32'(bus_e.x_q),       32'd0);
        check("arst_ones_q",    32'(bus_e.ones_q),    32'd0);
        check("arst_chk_err_q", 32'(bus_e.chk_err_q), 32'd0);
        @(negedge clk);
        check("arst_held_out_valid", 32'(bus_e.out_valid), 32'd0);
        drive_e(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(bus_e.out_valid), 32'd0);
        drive_e(1'b1, 8'h0F, 1'b0);
        @(negedge clk);
        check("post_rst_out_valid", 32'(bus_e.out_valid), 32'd1);
        check("post_rst_ones_q",    32'(bus_e.ones_q),    32'd4);
        check("post_rst_x_q",       32'(bus_e.x_q),       32'd0);

        // Back-to-back valid words.
        drive_e(1'b1, 8'hAA, 1'b0);
        @(negedge clk);
        check("b2b0_ones_q",    32'(bus_e.ones_q),    32'd4);
        check("b2b0_chk_err_q", 32'(bus_e.chk_err_q), 32'd0);
        drive_e(1'b1, 8'h80, 1'b0);
        @(negedge clk);
        check("b2b1_out_valid", 32'(bus_e.out_valid), 32'd1);
        check("b2b1_ones_q",    32'(bus_e.ones_q),    32'd1);
        check("b2b1_x_q",       32'(bus_e.x_q),       32'd1);
        check("b2b1_chk_err_q", 32'(bus_e.chk_err_q), 32'd1);
        drive_e(1'b0, 8'h00, 1'b0);

        // Odd-parity build.
        bus_o.a = 8'h00;
        #1;
        check("odd_x_00", 32'(bus_o.x), 32'd1);
        bus_o.a = 8'h01;
        #1;
        check("odd_x_01", 32'(bus_o.x), 32'd0);
        @(negedge clk);
        bus_o.in_valid = 1'b1;
        bus_o.a        = 8'h03;
        bus_o.chk_par  = 1'b1;
        @(negedge clk);
        check("odd_out_valid", 32'(bus_o.out_valid), 32'd1);
        check("odd_x_q",       32'(bus_o.x_q),       32'd1);
        check("odd_ones_q",    32'(bus_o.ones_q),    32'd2);
        check("odd_chk_err_q", 32'(bus_o.chk_err_q), 32'd0);
        bus_o.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
